// File: rtl/code_prog_if.sv
// Handshake bundle between the button shaper / switches and the
// passcode programming controller.
interface code_prog_if;
  logic        prog_req;
  logic [3:0]  digit_data;
  logic        digit_bpress;
  logic [15:0] code_out;
  logic        code_upd;
  logic        prog_busy;
  logic        prog_r;
  logic        prog_g;
  logic [2:0]  prog_state;

  modport master (
    output prog_req,
    output digit_data,
    output digit_bpress,
    input  code_out,
    input  code_upd,
    input  prog_busy,
    input  prog_r,
    input  prog_g,
    input  prog_state
  );

  modport slave (
    input  prog_req,
    input  digit_data,
    input  digit_bpress,
    output code_out,
    output code_upd,
    output prog_busy,
    output prog_r,
    output prog_g,
    output prog_state
  );
endinterface

// File: rtl/code_prog.sv
// Passcode programming controller: authenticate with the current
// code, enter the new code twice, commit only on a match.
module code_prog #(
  parameter logic [15:0] DEFAULT_CODE = 16'h3153,
  parameter int          TIMEOUT_CYC  = 50_000_000,
  parameter int          HOLD_CYC     = 25_000_000,
  parameter int          CNT_W        = 26
) (
  input  logic       CLK,
  input  logic       RST,
  code_prog_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AUTH    = 3'd1,
    S_NEW     = 3'd2,
    S_CONFIRM = 3'd3,
    S_OK      = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [11:0] entry_q, entry_d;
  logic [15:0] new_q, new_d;
  logic [15:0] code_q, code_d;
  logic        upd_q, upd_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;

  logic        enter;
  state_e      nxt;
  logic [15:0] full;
  logic        to_hit;
  logic        hold_hit;

  assign full     = {entry_q, bus.digit_data};
  assign to_hit   = (tmr_q == CNT_W'(TIMEOUT_CYC - 1));
  assign hold_hit = (tmr_q == CNT_W'(HOLD_CYC - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry_d = entry_q;
    new_d   = new_q;
    code_d  = code_q;
    upd_d   = 1'b0;
    tmr_d   = tmr_q;
    enter   = 1'b0;
    nxt     = state_q;

    case (state_q)
      S_IDLE: begin
        if (bus.prog_req) begin
          enter = 1'b1;
          nxt   = S_AUTH;
        end
      end
      S_AUTH, S_NEW, S_CONFIRM: begin
        if (bus.prog_req) begin
          enter = 1'b1;
          nxt   = S_AUTH;
          new_d = '0;
        end else if (bus.digit_bpress) begin
          tmr_d = '0;
          if (cnt_q == 2'd3) begin
            enter = 1'b1;
            unique case (1'b1)
              state_q == S_AUTH:
                nxt = (full == code_q) ? S_NEW : S_FAIL;
              state_q == S_NEW: begin
                nxt   = S_CONFIRM;
                new_d = full;
              end
              default: begin
                if (full == new_q) begin
                  nxt    = S_OK;
                  code_d = new_q;
                  upd_d  = 1'b1;
                end else begin
                  nxt = S_FAIL;
                end
              end
            endcase
          end else begin
            entry_d = full[11:0];
            cnt_d   = cnt_q + 2'd1;
          end
        end else if (to_hit) begin
          enter = 1'b1;
          nxt   = S_FAIL;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_OK, S_FAIL: begin
        if (bus.prog_req) begin
          enter = 1'b1;
          nxt   = S_AUTH;
        end else if (hold_hit) begin
          enter = 1'b1;
          nxt   = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        enter = 1'b1;
        nxt   = S_IDLE;
      end
    endcase

    // every state entry starts digit collection and timing afresh
    if (enter) begin
      state_d = nxt;
      cnt_d   = '0;
      entry_d = '0;
      tmr_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      entry_q <= '0;
      new_q   <= '0;
      code_q  <= DEFAULT_CODE;
      upd_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      new_q   <= new_d;
      code_q  <= code_d;
      upd_q   <= upd_d;
      tmr_q   <= tmr_d;
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_upd   = upd_q;
  assign bus.prog_busy  = (state_q == S_AUTH) || (state_q == S_NEW) ||
                          (state_q == S_CONFIRM);
  assign bus.prog_r     = (state_q == S_FAIL);
  assign bus.prog_g     = (state_q == S_OK);
  assign bus.prog_state = state_q;

endmodule
